hicore_ifu_fetch: RTL

Sequential instruction-fetch front end of the HiCore pipeline. It generates word-aligned fetch addresses, issues them on the instruction bus, tags each in-flight request with its PC, and pushes each response into the downstream bypass instruction buffer. It throttles on the buffer's half-full flag. On a pipeline redirect it restarts at the new PC, and every response already in flight is marked cancelled.

---
 rtl/hicore_ifu_fetch.sv | 120 ++++++++++++
 1 files changed

// File: rtl/hicore_ifu_fetch.sv
// Sequential fetch front end: issues word-aligned fetches, tags each with its PC, pushes responses.
// Response path is zero-latency; issue throttles on buffer half-full, outstanding limit and redirect.
module hicore_ifu_fetch #(
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = 32'h8000_0000,
  parameter int              OUTS     = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_vld,
  input  logic [PC_W-1:0]   redirect_pc,
  input  logic              buf_half_full,
  output logic              req_vld,
  input  logic              req_rdy,
  output logic [PC_W-1:0]   req_addr,
  input  logic              rsp_vld,
  output logic              rsp_rdy,
  input  logic [31:0]       rsp_data,
  input  logic              rsp_err,
  output logic              o_vld,
  input  logic              o_rdy,
  output logic [PC_W+32:0]  o_dat,
  output logic              o_cancel,
  output logic              flush
);

  localparam int PTR_W = $clog2(OUTS);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] OUTS_C = CNT_W'(OUTS);

  typedef struct packed {
    logic            err;
    logic [PC_W-1:0] pc;
    logic [31:0]     insn;
  } fetch_ent_t;

  logic [PC_W-1:0]  pc_q, pc_d;
  logic [CNT_W-1:0] outs_cnt_q, outs_cnt_d;
  logic [CNT_W-1:0] cancel_cnt_q, cancel_cnt_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PC_W-1:0]  tag_mem_q [OUTS];
  logic [PC_W-1:0]  tag_mem_d [OUTS];

  logic       req_fire;
  logic       rsp_fire;
  fetch_ent_t ent;

  // Issue is gated purely combinationally so a redirect or reset never leaks a stale request.
  always_comb begin
    req_vld  = ~rst & ~redirect_vld & ~buf_half_full & (outs_cnt_q < OUTS_C);
    req_addr = pc_q;
    req_fire = req_vld & req_rdy;
    rsp_rdy  = o_rdy;
    o_vld    = rsp_vld;
    rsp_fire = rsp_vld & o_rdy;
    flush    = redirect_vld;
    o_cancel = (cancel_cnt_q != '0) | redirect_vld;
    ent.err  = rsp_err;
    ent.pc   = tag_mem_q[rd_ptr_q];
    ent.insn = rsp_data;
    o_dat    = ent;
  end

  always_comb begin
    pc_d = pc_q;
    if (redirect_vld) begin
      pc_d = redirect_pc & ~PC_W'(3);
    end else if (req_fire) begin
      pc_d = pc_q + PC_W'(4);
    end
  end

  // Simultaneous push and pop leave the count unchanged; the FIFO cannot overflow since issue stops at OUTS.
  always_comb begin
    outs_cnt_d = outs_cnt_q + CNT_W'(req_fire) - CNT_W'(rsp_fire);
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    tag_mem_d  = tag_mem_q;
    if (req_fire) begin
      tag_mem_d[wr_ptr_q] = pc_q;
      wr_ptr_d            = wr_ptr_q + PTR_W'(1);
    end
    if (rsp_fire) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
  end

  // A redirect cancels whatever is still in flight once this cycle's response (if any) has drained.
  always_comb begin
    cancel_cnt_d = cancel_cnt_q;
    if (redirect_vld) begin
      cancel_cnt_d = outs_cnt_q - CNT_W'(rsp_fire);
    end else if (rsp_fire && (cancel_cnt_q != '0)) begin
      cancel_cnt_d = cancel_cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q         <= RESET_PC;
      outs_cnt_q   <= '0;
      cancel_cnt_q <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
    end else begin
      pc_q         <= pc_d;
      outs_cnt_q   <= outs_cnt_d;
      cancel_cnt_q <= cancel_cnt_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
    end
  end

  // Tag storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk) begin
    tag_mem_q <= tag_mem_d;
  end

endmodule
